// File: rtl/adc_audio_sampler.sv
// adc_audio_sampler: MCP3202-class SPI master producing signed 16-bit stereo samples once per period.
// Define ADC_AUDIO_MONO_EN to convert channel 0 only and copy it to both outputs.
module adc_audio_sampler #(
  parameter int CLK_DIV = 8,
  parameter int SAMPLE_PERIOD = 612
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        adc_miso,
  output logic        adc_clk,
  output logic        adc_cs,
  output logic        adc_mosi,
  output logic [15:0] sample_left,
  output logic [15:0] sample_right,
  output logic        sample_valid,
  output logic        overrun
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int PW = SAMPLE_PERIOD > 1 ? $clog2(SAMPLE_PERIOD) : 1;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;
  state_t state;
  logic [PW-1:0] period;
  logic [DW-1:0] div;
  logic [4:0] slot;
  logic high, chan, req, tick;
  logic [11:0] data;
`ifndef ADC_AUDIO_MONO_EN
  logic [11:0] left;
`endif
  assign req = period == '0 && enable;
  assign tick = div == DW'(CLK_DIV - 1);
  // command slots 0..3 are start, SGL, ODD, MSBF; everything after is don't-care zero
  function automatic logic cmd_bit(input logic [4:0] s, input logic ch);
    return s == 5'd2 ? ch : s < 5'd4;
  endfunction
  function automatic logic [15:0] to_pcm(input logic [11:0] d);
    return {~d[11], d[10:0], 4'b0000};
  endfunction
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      period <= '0;
      div <= '0;
      slot <= '0;
      high <= 1'b0;
      chan <= 1'b0;
      data <= '0;
`ifndef ADC_AUDIO_MONO_EN
      left <= '0;
`endif
      adc_cs <= 1'b1;
      adc_clk <= 1'b0;
      adc_mosi <= 1'b0;
      sample_left <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      period <= period == PW'(SAMPLE_PERIOD - 1) ? '0 : period + 1'b1;
      div <= state == IDLE || tick ? '0 : div + 1'b1;
      sample_valid <= 1'b0;
      overrun <= req && state != IDLE;
      case (state)
        IDLE: if (req) begin
          state <= SETUP;
          chan <= 1'b0;
          adc_cs <= 1'b0;
          adc_mosi <= 1'b1;
        end
        SETUP: if (tick) begin
          state <= SHIFT;
          slot <= '0;
          high <= 1'b0;
        end
        SHIFT: if (tick) begin
          high <= ~high;
          adc_clk <= ~high;
          // sample on the edge where SCK rises; slots 5..16 carry d[11]..d[0]
          if (!high && slot >= 5'd5) data <= {data[10:0], adc_miso};
          if (high && slot == 5'd16) begin
            state <= HOLD;
            adc_cs <= 1'b1;
            adc_mosi <= 1'b0;
          end else if (high) begin
            slot <= slot + 5'd1;
            adc_mosi <= cmd_bit(slot + 5'd1, chan);
          end
        end
        HOLD: if (tick) begin
`ifndef ADC_AUDIO_MONO_EN
          if (!chan) begin
            state <= SETUP;
            chan <= 1'b1;
            adc_cs <= 1'b0;
            adc_mosi <= 1'b1;
            left <= data;
          end else begin
            state <= DONE;
            sample_valid <= 1'b1;
            sample_left <= to_pcm(left);
            sample_right <= to_pcm(data);
          end
`else
          state <= DONE;
          sample_valid <= 1'b1;
          sample_left <= to_pcm(data);
          sample_right <= to_pcm(data);
`endif
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_audio_sampler.sv
// tb_adc_audio_sampler: random ADC codes against a behavioural ADC and frame-schedule model.
module tb_adc_audio_sampler;
  localparam int D = 2;
`ifdef ADC_AUDIO_MONO_EN
  localparam int NCH = 1;
  localparam int V0 = 'hABC;
`else
  localparam int NCH = 2;
  localparam int V0 = 'h800;
`endif
  localparam int LAT = 36 * D * NCH + 1;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, done = 1'b0;
  logic miso[2], cs[2], sck[2], mosi[2], sv[2], ovr[2];
  logic [15:0] sl[2], sr[2];
  int checks = 0, errors = 0, cyc = 0;
  int per[2] = '{200, 100};
  int pc[2], strobe_at[2], busy_end[2], ovr_at[2], start_at[2], cs_rise[2], last_rise[2], n[2], frm[2], k[2];
  int val[2][2];
  logic [15:0] hl[2], hr[2];
  logic [16:0] cmd[2];
  logic prev_cs[2], prev_sck[2];
  logic prev_rst = 1'b1;
  always #5 clk = ~clk;
  adc_audio_sampler #(.CLK_DIV(D), .SAMPLE_PERIOD(200)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .adc_miso(miso[0]), .adc_clk(sck[0]), .adc_cs(cs[0]),
    .adc_mosi(mosi[0]), .sample_left(sl[0]), .sample_right(sr[0]), .sample_valid(sv[0]), .overrun(ovr[0]));
  adc_audio_sampler #(.CLK_DIV(D), .SAMPLE_PERIOD(100)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .adc_miso(miso[1]), .adc_clk(sck[1]), .adc_cs(cs[1]),
    .adc_mosi(mosi[1]), .sample_left(sl[1]), .sample_right(sr[1]), .sample_valid(sv[1]), .overrun(ovr[1]));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] conv(input int v);
    return 16'((v - 2048) * 16);
  endfunction
  function automatic int pick(input int kk, input int ch);
    return kk == 0 ? (ch != 0 ? 'hFFF : V0) : kk == 1 ? (ch != 0 ? 'h123 : 0) :
           kk == 2 ? (ch != 0 ? 0 : 'hFFF) : int'($urandom_range(4095, 0));
  endfunction
  initial begin
    for (int g = 0; g < 2; g++) begin
      pc[g] = 0; strobe_at[g] = -1; busy_end[g] = -1; ovr_at[g] = -1; start_at[g] = -1;
      cs_rise[g] = 0; last_rise[g] = 0; n[g] = 0; frm[g] = 0; k[g] = 0;
      val[g][0] = pick(0, 0); val[g][1] = pick(0, 1);
      hl[g] = '0; hr[g] = '0; cmd[g] = '0; prev_cs[g] = 1'b1; prev_sck[g] = 1'b0; miso[g] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (done) begin
        check("strobes0", 32'(k[0] > 4), 1);
        check("strobes1", 32'(k[1] > 4), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
      for (int g = 0; g < 2; g++) begin
        logic ev;
        int ch;
        ev = cyc == strobe_at[g];
        if (ev) begin
          hl[g] = conv(val[g][0]);
          hr[g] = conv(val[g][NCH-1]);
        end
        check($sformatf("valid%0d", g), sv[g], ev);
        check($sformatf("overrun%0d", g), ovr[g], cyc == ovr_at[g]);
        check($sformatf("left%0d", g), sl[g], hl[g]);
        check($sformatf("right%0d", g), sr[g], hr[g]);
        if (ev) begin
          k[g]++;
          val[g][0] = pick(k[g], 0);
          val[g][1] = pick(k[g], 1);
        end
        if (prev_rst) begin
          check($sformatf("rst_cs%0d", g), cs[g], 1);
          check($sformatf("rst_sck%0d", g), sck[g], 0);
          check($sformatf("rst_mosi%0d", g), mosi[g], 0);
        end
        if (prev_cs[g] && !cs[g]) begin
          if (frm[g] % NCH != 0) check($sformatf("cs_gap%0d", g), cyc - cs_rise[g], D);
          else check($sformatf("cs_start%0d", g), cyc - start_at[g], 1);
          n[g] = 0;
          cmd[g] = '0;
          miso[g] = 1'b0;
        end
        if (!cs[g] && sck[g] && !prev_sck[g]) begin
          if (n[g] > 0) check($sformatf("sck_per%0d", g), cyc - last_rise[g], 2 * D);
          if (n[g] < 17) cmd[g][n[g]] = mosi[g];
          last_rise[g] = cyc;
          n[g]++;
        end
        if (!cs[g] && !sck[g] && prev_sck[g]) begin
          ch = NCH == 2 ? int'(cmd[g][2]) : 0;
          miso[g] = n[g] >= 5 && n[g] <= 16 ? val[g][ch][16 - n[g]] : 1'b0;
        end
        if (!prev_cs[g] && cs[g] && !prev_rst) begin
          check($sformatf("pulses%0d", g), n[g], 17);
          check($sformatf("cmd%0d", g), cmd[g][3:0], {1'b1, NCH == 2 && frm[g] % 2 == 1, 2'b11});
          frm[g]++;
          cs_rise[g] = cyc;
        end
        if (reset) begin
          strobe_at[g] = -1; busy_end[g] = -1; ovr_at[g] = -1;
          hl[g] = '0; hr[g] = '0; frm[g] = 0; n[g] = 0; miso[g] = 1'b0;
        end else if (pc[g] == 0 && enable) begin
          if (cyc > busy_end[g]) begin
            start_at[g] = cyc;
            strobe_at[g] = cyc + LAT;
            busy_end[g] = cyc + LAT;
          end else ovr_at[g] = cyc + 1;
        end
        pc[g] = reset ? 0 : (pc[g] + 1) % per[g];
        prev_cs[g] = cs[g];
        prev_sck[g] = sck[g];
      end
      prev_rst = reset;
      cyc++;
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    enable = 1'b1;
    repeat (1200) @(posedge clk);
    for (int i = 0; i < 250 && pc[0] != 0; i++) @(posedge clk);
    repeat (100) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (800) @(posedge clk);
    for (int i = 0; i < 250 && pc[0] != 0; i++) @(posedge clk);
    repeat (20) @(posedge clk);
    #1 enable = 1'b0;
    repeat (500) @(posedge clk);
    #1 enable = 1'b1;
    repeat (600) @(posedge clk);
    done = 1'b1;
  end
endmodule
